multicycle_sequencer: RTL and testbench



---
 rtl/multicycle_sequencer_if.sv | 27 ++
 rtl/multicycle_sequencer.sv | 103 ++++++++++
 tb/tb_multicycle_sequencer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_sequencer_if.sv
// Fetch-side and control-unit-side signals of the multicycle sequencer.
// The slave modport is the sequencer. The master modport is its environment.
interface multicycle_sequencer_if #(
    parameter int OPW = 5
);
    logic [OPW-1:0] fetchOpCode;
    logic           fetchValid;
    logic           interrupt;
    logic           stall;
    logic           flush;
    logic [OPW-1:0] opCode;
    logic           makeMeBubble;
    logic           pcHold;
    logic           intAck;
    logic           illegalOp;
    logic           busy;

    modport slave (
        input  fetchOpCode, fetchValid, interrupt, stall, flush,
        output opCode, makeMeBubble, pcHold, intAck, illegalOp, busy
    );

    modport master (
        output fetchOpCode, fetchValid, interrupt, stall, flush,
        input  opCode, makeMeBubble, pcHold, intAck, illegalOp, busy
    );
endinterface

// File: rtl/multicycle_sequencer.sv
// Sits in front of the control unit. It passes single-cycle opcodes through,
// expands CALL/RET/RTI into two parts, and injects the interrupt pair.
module multicycle_sequencer #(
    parameter int OPW       = 5,
    parameter bit INT_LEVEL = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    multicycle_sequencer_if.slave bus
);
    localparam logic [OPW-1:0] OP_NOP   = '0;
    localparam logic [OPW-1:0] OP_CALL1 = OPW'(5'b11000);
    localparam logic [OPW-1:0] OP_CALL2 = OPW'(5'b11001);
    localparam logic [OPW-1:0] OP_RET1  = OPW'(5'b11010);
    localparam logic [OPW-1:0] OP_RET2  = OPW'(5'b11011);
    localparam logic [OPW-1:0] OP_RTI1  = OPW'(5'b11100);
    localparam logic [OPW-1:0] OP_RTI2  = OPW'(5'b11101);
    localparam logic [OPW-1:0] OP_INT1  = OPW'(5'b11110);
    localparam logic [OPW-1:0] OP_INT2  = OPW'(5'b11111);

    typedef enum logic [2:0] {IDLE, CALL2, RET2, RTI2, INT2} state_t;

    state_t         state, state_n;
    logic           int_pend, int_pend_n, int_q, int_set;
    logic [OPW-1:0] op_q, op_n;
    logic           bub_q, bub_n, ack_q, ack_n, ill_q, ill_n;
    logic           hold;

    // A new request always wins over the clear from this edge's 11110 issue.
    assign int_set = INT_LEVEL ? bus.interrupt : (bus.interrupt & ~int_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            int_pend <= 1'b0;
            int_q    <= 1'b0;
            op_q     <= OP_NOP;
            bub_q    <= 1'b1;
            ack_q    <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            state    <= state_n;
            int_pend <= int_pend_n;
            int_q    <= bus.interrupt;
            op_q     <= op_n;
            bub_q    <= bub_n;
            ack_q    <= ack_n;
            ill_q    <= ill_n;
        end
    end

    always_comb begin
        state_n    = state;
        int_pend_n = int_pend | int_set;
        op_n       = OP_NOP;
        bub_n      = 1'b1;
        ack_n      = 1'b0;
        ill_n      = 1'b0;
        hold       = 1'b1;
        if (!bus.stall) begin
            case (state)
                IDLE: begin
                    if (int_pend && !bus.flush) begin
                        op_n       = OP_INT1;
                        bub_n      = 1'b0;
                        ack_n      = 1'b1;
                        state_n    = INT2;
                        int_pend_n = int_set;
                    end else if (bus.flush || !bus.fetchValid) begin
                        hold = 1'b0;
                    end else begin
                        hold  = 1'b0;
                        bub_n = 1'b0;
                        // Second-part and interrupt opcodes are internal only.
                        if (bus.fetchOpCode inside {OP_CALL2, OP_RET2, OP_RTI2, OP_INT1, OP_INT2}) begin
                            ill_n = 1'b1;
                        end else begin
                            op_n = bus.fetchOpCode;
                            case (bus.fetchOpCode)
                                OP_CALL1: state_n = CALL2;
                                OP_RET1:  state_n = RET2;
                                OP_RTI1:  state_n = RTI2;
                                default:  state_n = IDLE;
                            endcase
                        end
                    end
                end
                CALL2: begin op_n = OP_CALL2; bub_n = 1'b0; state_n = IDLE; end
                RET2:  begin op_n = OP_RET2;  bub_n = 1'b0; state_n = IDLE; end
                RTI2:  begin op_n = OP_RTI2;  bub_n = 1'b0; state_n = IDLE; end
                INT2:  begin op_n = OP_INT2;  bub_n = 1'b0; state_n = IDLE; end
                default: state_n = IDLE;
            endcase
        end
    end

    assign bus.opCode       = op_q;
    assign bus.makeMeBubble = bub_q;
    assign bus.intAck       = ack_q;
    assign bus.illegalOp    = ill_q;
    assign bus.pcHold       = hold;
    assign bus.busy         = (state != IDLE);
endmodule

// File: tb/tb_multicycle_sequencer.sv
// Random plus directed stimulus against a queue-based reference model.
// A monitor pops the expected registered outputs after every clock edge.
module tb_multicycle_sequencer;
    localparam bit INT_LEVEL = 1'b0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_sequencer_if #(.OPW(5)) bus ();
    multicycle_sequencer #(.OPW(5), .INT_LEVEL(INT_LEVEL)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [4:0] op;
        logic       bub;
        logic       ack;
        logic       ill;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;

    // Reference model: a queue of internal opcodes still owed to the control unit.
    logic [4:0] m_todo[$];
    bit         m_pend = 1'b0;
    bit         m_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_reserved(input logic [4:0] op);
        return op inside {5'b11001, 5'b11011, 5'b11101, 5'b11110, 5'b11111};
    endfunction

    // One clock of stimulus. The expected result of the coming edge is pushed to the scoreboard.
    task automatic cyc(input bit v, input logic [4:0] op, input bit intr, input bit st, input bit fl);
        exp_t e;
        bit   set, hold;
        @(negedge clk);
        bus.fetchValid  = v;
        bus.fetchOpCode = op;
        bus.interrupt   = intr;
        bus.stall       = st;
        bus.flush       = fl;
        #1;
        set   = INT_LEVEL ? intr : (intr && !m_prev);
        e     = '{op: 5'b00000, bub: 1'b1, ack: 1'b0, ill: 1'b0};
        hold  = 1'b1;
        chk("busy", bus.busy, m_todo.size() != 0);
        if (st) begin
            m_pend = m_pend | set;
        end else if (m_todo.size() != 0) begin
            e.op   = m_todo.pop_front();
            e.bub  = 1'b0;
            m_pend = m_pend | set;
        end else if (m_pend && !fl) begin
            e.op  = 5'b11110;
            e.bub = 1'b0;
            e.ack = 1'b1;
            m_todo.push_back(5'b11111);
            m_pend = set;
        end else begin
            hold   = 1'b0;
            m_pend = m_pend | set;
            if (v && !fl) begin
                e.bub = 1'b0;
                if (is_reserved(op)) e.ill = 1'b1;
                else begin
                    e.op = op;
                    if (op == 5'b11000 || op == 5'b11010 || op == 5'b11100)
                        m_todo.push_back(op + 5'd1);
                end
            end
        end
        m_prev = intr;
        chk("pcHold", bus.pcHold, hold);
        sb.push_back(e);
    endtask

    task automatic idle_inputs();
        bus.fetchValid  = 1'b0;
        bus.fetchOpCode = 5'b00000;
        bus.interrupt   = 1'b0;
        bus.stall       = 1'b0;
        bus.flush       = 1'b0;
    endtask

    task automatic model_reset();
        sb.delete();
        m_todo.delete();
        m_pend = 1'b0;
        m_prev = 1'b0;
    endtask

    // Monitor: registered outputs are compared after every edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && sb.size() > 0) begin
                e = sb.pop_front();
                chk("opCode", bus.opCode, e.op);
                chk("makeMeBubble", bus.makeMeBubble, e.bub);
                chk("intAck", bus.intAck, e.ack);
                chk("illegalOp", bus.illegalOp, e.ill);
            end
        end
    end

    initial begin
        logic [4:0] firsts[3];
        logic [4:0] resv[5];
        logic [4:0] op;
        firsts = '{5'b11000, 5'b11010, 5'b11100};
        resv   = '{5'b11001, 5'b11011, 5'b11101, 5'b11110, 5'b11111};
        idle_inputs();
        #23;
        chk("rst_opCode", bus.opCode, 5'b00000);
        chk("rst_bubble", bus.makeMeBubble, 1'b1);
        chk("rst_intAck", bus.intAck, 1'b0);
        chk("rst_illegal", bus.illegalOp, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // CALL then a plain opcode that fetch holds for one cycle.
        cyc(1, 5'b11000, 0, 0, 0);
        cyc(1, 5'b01001, 0, 0, 0);
        cyc(1, 5'b01001, 0, 0, 0);
        // RTI with a 2-cycle stall in the second part.
        cyc(1, 5'b11100, 0, 0, 0);
        cyc(1, 5'b00010, 0, 1, 0);
        cyc(1, 5'b00010, 0, 1, 0);
        cyc(1, 5'b00010, 0, 0, 0);
        // Interrupt pulse during RET2.
        cyc(1, 5'b11010, 0, 0, 0);
        cyc(1, 5'b00011, 1, 0, 0);
        cyc(1, 5'b00011, 0, 0, 0);
        cyc(1, 5'b00011, 0, 0, 0);
        cyc(1, 5'b00011, 0, 0, 0);
        // Interrupt deferred by flush.
        cyc(1, 5'b00101, 1, 0, 0);
        cyc(1, 5'b00110, 0, 0, 1);
        cyc(1, 5'b00110, 0, 0, 0);
        cyc(1, 5'b00110, 0, 0, 0);
        cyc(1, 5'b00110, 0, 0, 0);
        // Two edges merge into a single request while stalled.
        cyc(0, 5'b00000, 1, 1, 0);
        cyc(0, 5'b00000, 0, 1, 0);
        cyc(0, 5'b00000, 1, 1, 0);
        cyc(0, 5'b00000, 0, 0, 0);
        cyc(0, 5'b00000, 0, 0, 0);
        cyc(0, 5'b00000, 0, 0, 0);
        // Reserved opcode from fetch.
        cyc(1, 5'b11111, 0, 0, 0);
        cyc(0, 5'b00000, 0, 0, 0);
        // Back-to-back CALLs.
        cyc(1, 5'b11000, 0, 0, 0);
        cyc(1, 5'b11000, 0, 0, 0);
        cyc(1, 5'b11000, 0, 0, 0);
        cyc(0, 5'b00000, 0, 0, 0);

        // Asynchronous reset while the CALL second part is still owed.
        cyc(1, 5'b11000, 0, 0, 0);
        @(negedge clk);
        #2;
        chk("busy_pre_rst", bus.busy, 1'b1);
        idle_inputs();
        rst = 1'b1;
        #1;
        chk("midrst_opCode", bus.opCode, 5'b00000);
        chk("midrst_bubble", bus.makeMeBubble, 1'b1);
        chk("midrst_busy", bus.busy, 1'b0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cyc(1, 5'b01001, 0, 0, 0);
        cyc(0, 5'b00000, 0, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 3) op = firsts[$urandom_range(0, 2)];
            else if (r == 3) op = resv[$urandom_range(0, 4)];
            else op = 5'($urandom);
            cyc($urandom_range(0, 9) < 8, op, $urandom_range(0, 9) < 2,
                $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 1);
        end

        @(posedge clk);
        #2;
        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
